// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands and start; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first,
// one bit per clock through a 1-bit full-subtractor cell and a borrow flop.
// Only one operation is in flight; start is ignored while busy.
// WIDTH must be at least 2.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    // Operand sign bits are kept aside because the shift registers lose them.
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;

    logic               d_bit;
    logic               br_next;
    logic               last_bit;

    // Full-subtractor cell acting on the current operand LSBs and borrow.
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Publish the result only once it is complete.
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back checks for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: {ovf, bout, diff}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0]   full;
        logic [W-1:0] d;
        logic         ov;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d    = full[W-1:0];
        ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {ov, full[W], d};
    endfunction

    // Issue one operation from IDLE (called at a negedge with busy low) and
    // check latency, busy length, result and that diff holds during SHIFT.
    // With interfere set, start is pulsed during SHIFT and during DONE.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                          input logic exp_o, input bit interfere);
        logic [W-1:0] prev_diff;
        int busy_cnt;
        int lat;
        bit got;
        prev_diff = bus.diff;
        busy_cnt  = 0;
        lat       = -1;
        got       = 1'b0;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 30 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (k == 4) check({name, " diff_hold"}, 32'(bus.diff), 32'(prev_diff));
            if (bus.done) begin
                got = 1'b1;
                lat = k - 1;
                check({name, " diff"}, 32'(bus.diff), 32'(exp_d));
                check({name, " bout"}, 32'(bus.bout), 32'(exp_b));
                check({name, " ovf"},  32'(bus.ovf),  32'(exp_o));
            end
            if (interfere) begin
                if (k == 3 || bus.done) begin
                    bus.start = 1'b1;
                    bus.a     = 8'd200;
                    bus.b     = 8'd1;
                end else if (k == 4) begin
                    bus.start = 1'b0;
                end
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(lat), 32'(W));
        check({name, " busy_len"}, 32'(busy_cnt), 32'(W + 1));
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " done_pulse"}, 32'(bus.done), 32'd0);
        check({name, " busy_end"}, 32'(bus.busy), 32'd0);
        $display("op %s: a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d ovf=%0d lat=%0d",
                 name, a, b, bin, bus.diff, bus.bout, bus.ovf, lat);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst diff", 32'(bus.diff), 32'd0);
        check("rst bout", 32'(bus.bout), 32'd0);
        check("rst ovf",  32'(bus.ovf),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary operations
        run_op("t1",   8'd100, 8'd58, 1'b0, 8'd42,  1'b0, 1'b0, 1'b0);
        run_op("t2a",  8'h00,  8'h01, 1'b0, 8'hFF,  1'b1, 1'b0, 1'b0);
        run_op("t2b",  8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1, 1'b0);
        run_op("t3a",  8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1, 1'b0);
        run_op("t3b",  8'd5,   8'd3,  1'b1, 8'd1,   1'b0, 1'b0, 1'b0);

        // start while busy is ignored
        run_op("t4",   8'd10,  8'd3,  1'b0, 8'd7,   1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t4 no_done", 32'(bus.done), 32'd0);
            check("t4 idle",    32'(bus.busy), 32'd0);
            check("t4 diff",    32'(bus.diff), 32'd7);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of SHIFT
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5 busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5 busy", 32'(bus.busy), 32'd0);
        check("t5 done", 32'(bus.done), 32'd0);
        check("t5 diff", 32'(bus.diff), 32'd0);
        check("t5 bout", 32'(bus.bout), 32'd0);
        check("t5 ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t5 no_done", 32'(bus.done), 32'd0);
        end
        $display("op t5: reset mid-operation, outputs cleared");
        run_op("t5b", 8'd3, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high
        begin
            int cyc;
            int last;
            int ops;
            logic [W+1:0] exp_r;
            logic [W-1:0] ra, rb;
            logic rbin;
            cyc   = 0;
            last  = -1;
            ops   = 0;
            exp_r = '0;
            ra    = '0;
            rb    = '0;
            rbin  = 1'b0;
            bus.start = 1'b1;
            while (ops < 200 && cyc < 5000) begin
                if (!bus.busy) begin
                    ra      = W'($urandom);
                    rb      = W'($urandom);
                    rbin    = 1'($urandom);
                    bus.a   = ra;
                    bus.b   = rb;
                    bus.bin = rbin;
                    exp_r   = model(ra, rb, rbin);
                end
                @(negedge clk);
                cyc++;
                if (bus.done) begin
                    check("t6 result", 32'({bus.ovf, bus.bout, bus.diff}), 32'(exp_r));
                    if (last >= 0) check("t6 spacing", 32'(cyc - last), 32'(W + 2));
                    $display("op t6.%0d: a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d ovf=%0d",
                             ops, ra, rb, rbin, bus.diff, bus.bout, bus.ovf);
                    last = cyc;
                    ops++;
                end
            end
            check("t6 op_count", 32'(ops), 32'd200);
            bus.start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
